fetch_stage_ctrl: RTL
=====================

Name: fetch_stage_ctrl

Overview:
- Consumer end of the pipeline hazard-control interface. Applies the stall/flush commands produced by the hazard unit to the front of the pipeline.
- Owns the program counter (PC), the instruction-memory address, and the IF/ID pipeline register.
- Accepts branch redirects from EX and holds any redirect that arrives during a PC stall until the PC may advance.
- Sits between instruction memory and the decode stage.

Parameters:
- ADDR_W, 32, width of PC and instruction address
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment
- NOP_INSTR, 32'h00000013, instruction inserted on flush/reset (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- pc_write  in  1  from hazard unit; 1 = PC may update
- ifid_write  in  1  from hazard unit; 1 = IF/ID may load
- ifid_flush  in  1  from hazard unit; 1 = IF/ID becomes bubble
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  ADDR_W  target address of redirect
- imem_addr  out  ADDR_W  instruction fetch address (= pc, combinational)
- imem_rdata  in  INSTR_W  instruction at imem_addr (combinational memory)
- pc  out  ADDR_W  current PC register
- ifid_pc  out  ADDR_W  PC of instruction in IF/ID
- ifid_instr  out  INSTR_W  instruction in IF/ID
- ifid_valid  out  1  1 = IF/ID holds a real instruction
- redirect_pending  out  1  a redirect is latched awaiting pc_write
- stall_cnt  out  32  stall-cycle counter (optional feature)
- flush_cnt  out  32  flush counter (optional feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; ifid_pc=0; ifid_instr=NOP_INSTR; ifid_valid=0
  - redirect_pending=0; pending target=0; stall_cnt=flush_cnt=0
  - Reset asserted mid-stall or with a redirect pending discards all state.
- imem_addr = pc at all times.
- PC update, evaluated each rising edge in priority order:
  1. redirect_valid=1 and pc_write=1: pc <= redirect_target; clear pending.
  2. redirect_valid=1 and pc_write=0: latch redirect_target into pending; redirect_pending <= 1. A newer redirect overwrites an older pending one.
  3. redirect_pending=1 and pc_write=1: pc <= pending target; redirect_pending <= 0.
  4. pc_write=1: pc <= pc + PC_STEP, modulo 2^ADDR_W (wraps from max to 0, no flag).
  5. Otherwise: pc holds.
- IF/ID update, evaluated each rising edge in priority order:
  1. ifid_flush=1: ifid_instr <= NOP_INSTR, ifid_valid <= 0, ifid_pc holds. Flush beats ifid_write.
  2. ifid_write=1: ifid_instr <= imem_rdata, ifid_pc <= pc. ifid_valid <= 1, except it is 0 when redirect_valid=1 or redirect_pending=1 in that cycle, because the fetched instruction is wrong-path.
  3. Otherwise: all IF/ID fields hold.
- Latency:
  - Redirect accepted at edge N: imem_addr = target after edge N; ifid_pc = target with ifid_valid=1 after edge N+1, provided ifid_write=1 and no flush.
  - A stalled redirect takes effect on the first edge where pc_write=1, with the same latency measured from that edge.
- The inputs pc_write=0, ifid_write=1 are legal: IF/ID reloads the same pc each cycle; no error is raised.
- No combinational path from inputs to outputs, except imem_addr = pc.

Optional Feature:
- Macro: FETCH_PERF_EN
- Defined:
  - stall_cnt increments on each edge with pc_write=0.
  - flush_cnt increments on each edge with ifid_flush=1.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, and reset to 0.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter registers are built. Port list is unchanged.

Test Plan:
- Reset release, pc_write=ifid_write=1 for 3 cycles, imem returns 0x111/0x222/0x333 -> pc=0x0C; ifid_pc=0x08, ifid_instr=0x333, ifid_valid=1.
- At pc=0x10, hold pc_write=ifid_write=0 for 2 cycles, then resume -> pc stays 0x10 for 2 cycles, then 0x14. With FETCH_PERF_EN, stall_cnt=2.
- At pc=0x20, redirect_valid=1, target=0x100, ifid_flush=1, pc_write=1 -> next pc=0x100, ifid_valid=0, ifid_instr=0x00000013. One cycle later ifid_pc=0x100, ifid_valid=1.
- redirect target 0x200 with pc_write=0 -> redirect_pending=1, pc held. Next cycle redirect 0x300 with pc_write=0 -> pending target overwritten. pc_write=1 -> pc=0x300, redirect_pending=0.
- pc=0xFFFFFFFC with pc_write=1 -> pc=0x00000000.
- Drive rst low while redirect_pending=1 and mid-stall -> all outputs at reset values immediately, before any clock edge.

Source files
------------

// File: rtl/fetch_stage_ctrl_if.sv
// Fetch-stage bundle: hazard commands, redirect, instruction memory port
// and the IF/ID / PC state seen by decode.
interface fetch_stage_ctrl_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  localparam int unsigned CNT_W = 32;

  logic               pc_write;
  logic               ifid_write;
  logic               ifid_flush;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  ifid_pc;
  logic [INSTR_W-1:0] ifid_instr;
  logic               ifid_valid;
  logic               redirect_pending;
  logic [CNT_W-1:0]   stall_cnt;
  logic [CNT_W-1:0]   flush_cnt;

  // Environment side: hazard unit, EX redirect, instruction memory, decode
  modport master (
    output pc_write, ifid_write, ifid_flush, redirect_valid, redirect_target, imem_rdata,
    input  imem_addr, pc, ifid_pc, ifid_instr, ifid_valid, redirect_pending,
           stall_cnt, flush_cnt
  );

  // Fetch controller side
  modport slave (
    input  pc_write, ifid_write, ifid_flush, redirect_valid, redirect_target, imem_rdata,
    output imem_addr, pc, ifid_pc, ifid_instr, ifid_valid, redirect_pending,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns PC, IF/ID register and a one-deep latch for
// redirects that arrive while the PC is stalled.
// Optional build macro FETCH_PERF_EN adds saturating stall/flush counters.
module fetch_stage_ctrl #(
  parameter int unsigned        ADDR_W    = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter int unsigned        PC_STEP   = 4,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
  input logic              clk,
  input logic              rst,
  fetch_stage_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 32;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pend_q, pend_d;
  logic [ADDR_W-1:0]  pend_tgt_q, pend_tgt_d;
  logic [ADDR_W-1:0]  ifid_pc_q, ifid_pc_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               ifid_valid_q, ifid_valid_d;

  // PC next-state: live redirect, then pending redirect, then sequential step
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (bus.redirect_valid && bus.pc_write) begin
      pc_d   = bus.redirect_target;
      pend_d = 1'b0;
    end else if (bus.redirect_valid) begin
      pend_tgt_d = bus.redirect_target;
      pend_d     = 1'b1;
    end else if (pend_q && bus.pc_write) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end else if (bus.pc_write) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // IF/ID next-state: flush wins; a fetch under any redirect is wrong-path
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.ifid_flush) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (bus.ifid_write) begin
      ifid_instr_d = bus.imem_rdata;
      ifid_pc_d    = pc_q;
      ifid_valid_d = !(bus.redirect_valid || pend_q);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_tgt_q   <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!bus.pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (bus.ifid_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = CNT_W'(0);
  assign bus.flush_cnt = CNT_W'(0);
`endif

  assign bus.imem_addr        = pc_q;
  assign bus.pc               = pc_q;
  assign bus.ifid_pc          = ifid_pc_q;
  assign bus.ifid_instr       = ifid_instr_q;
  assign bus.ifid_valid       = ifid_valid_q;
  assign bus.redirect_pending = pend_q;

endmodule
